// File: rtl/mac_coprocessor.sv
// Multi-cycle multiply-accumulate coprocessor sitting beside the execute stage.
// Holds a 64-bit accumulator; MACW/RDHI write a 32-bit result back through a one-cycle strobe.
module mac_coprocessor #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_e,
  input  logic [1:0]  op_e,
  input  logic [31:0] rs1_val_e,
  input  logic [31:0] rs2_val_e,
  input  logic [4:0]  rd_e,
  input  logic        flush_e,
  output logic        in_ready_e,
  output logic        stall_o,
  output logic        busy_o,
  output logic        result_valid_w,
  output logic [31:0] result_w,
  output logic [4:0]  rd_w
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  localparam logic [1:0] OP_MAC  = 2'b00;
  localparam logic [1:0] OP_MACW = 2'b01;
  localparam logic [1:0] OP_RDHI = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_t             state;
  logic [3:0]         cnt;
  logic [1:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [4:0]         rd_q;
  logic [63:0]        acc;
  logic signed [63:0] product;
  logic [63:0]        acc_next;
  logic               accept;
  logic               last_cycle;

  assign in_ready_e = (state == IDLE);
  assign busy_o     = (state != IDLE);
  assign stall_o    = in_valid_e & ~in_ready_e & ~flush_e;
  assign accept     = in_valid_e & in_ready_e & ~flush_e;
  assign last_cycle = (cnt == 4'(MUL_CYCLES - 1));

  // Product is formed from captured operands and treated as a MUL_CYCLES multicycle path.
  assign product  = 64'($signed(a_q)) * 64'($signed(b_q));
  assign acc_next = acc + product;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      op_q           <= OP_MAC;
      a_q            <= '0;
      b_q            <= '0;
      rd_q           <= '0;
      acc            <= '0;
      result_valid_w <= 1'b0;
      result_w       <= '0;
      rd_w           <= '0;
    end else begin
      result_valid_w <= 1'b0;
      result_w       <= '0;
      rd_w           <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op_e;
            a_q  <= rs1_val_e;
            b_q  <= rs2_val_e;
            rd_q <= rd_e;
            cnt  <= '0;
            if (op_e == OP_CLR) begin
              acc <= '0;
            end else if (op_e == OP_RDHI) begin
              state <= DONE;
              if (rd_e != '0) begin
                result_valid_w <= 1'b1;
                result_w       <= acc[63:32];
                rd_w           <= rd_e;
              end
            end else begin
              state <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          // Flush wins over completion: an aborted op never touches acc.
          if (flush_e) begin
            state <= IDLE;
          end else if (last_cycle) begin
            acc   <= acc_next;
            state <= DONE;
            if (op_q == OP_MACW && rd_q != '0) begin
              result_valid_w <= 1'b1;
              result_w       <= acc_next[31:0];
              rd_w           <= rd_q;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_coprocessor.sv
// Randomized self-checking bench for mac_coprocessor against an arithmetic accumulator model.
module tb_mac_coprocessor;

  localparam int MC = 3;

  logic        clk;
  logic        rst;
  logic        in_valid_e;
  logic [1:0]  op_e;
  logic [31:0] rs1_val_e;
  logic [31:0] rs2_val_e;
  logic [4:0]  rd_e;
  logic        flush_e;
  logic        in_ready_e;
  logic        stall_o;
  logic        busy_o;
  logic        result_valid_w;
  logic [31:0] result_w;
  logic [4:0]  rd_w;

  int checks   = 0;
  int failures = 0;
  longint acc_m = 0;

  typedef struct {
    int          busy_cyc;
    int          strobes;
    int          strobe_at;
    logic [31:0] res;
    logic [4:0]  rdw;
    int          leak;
    int          stall_bad;
    bit          timeout;
  } obs_t;

  mac_coprocessor #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .in_valid_e(in_valid_e), .op_e(op_e),
    .rs1_val_e(rs1_val_e), .rs2_val_e(rs2_val_e), .rd_e(rd_e), .flush_e(flush_e),
    .in_ready_e(in_ready_e), .stall_o(stall_o), .busy_o(busy_o),
    .result_valid_w(result_valid_w), .result_w(result_w), .rd_w(rd_w)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Issue one op, holding in_valid like a stalled pipeline until the unit is ready again.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit flush_done, output obs_t o);
    int done_idx;
    o = '{default: 0};
    done_idx = (op == 2'b10) ? 1 : MC + 1;
    @(negedge clk);
    in_valid_e = 1; op_e = op; rs1_val_e = a; rs2_val_e = b; rd_e = rd; flush_e = 0;
    #1;
    if (!in_ready_e || stall_o) o.stall_bad++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      flush_e = 0;
      if (in_ready_e) begin
        in_valid_e = 0;
        break;
      end
      o.busy_cyc++;
      if (result_valid_w) begin
        o.strobes++; o.strobe_at = k; o.res = result_w; o.rdw = rd_w;
      end else if (result_w !== 32'd0 || rd_w !== 5'd0) begin
        o.leak++;
      end
      if (flush_done && k == done_idx) flush_e = 1;
      #1;
      if (stall_o !== !flush_e) o.stall_bad++;
      if (busy_o !== 1'b1) o.stall_bad++;
      if (k == 40) o.timeout = 1;
    end
  endtask

  // Reference: update model accumulator, return expected writeback.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output bit exp_strobe, output logic [31:0] exp_res,
                       output int exp_busy);
    int ia, ib;
    longint la, lb;
    ia = a; ib = b; la = ia; lb = ib;
    exp_strobe = 0; exp_res = 0;
    case (op)
      2'b00: begin acc_m = acc_m + la * lb; exp_busy = MC + 1; end
      2'b01: begin
        acc_m = acc_m + la * lb; exp_busy = MC + 1;
        exp_strobe = (rd != 0); exp_res = acc_m[31:0];
      end
      2'b10: begin exp_busy = 1; exp_strobe = (rd != 0); exp_res = acc_m[63:32]; end
      default: begin acc_m = 0; exp_busy = 0; end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid_e = 0; flush_e = 0;
    @(negedge clk);
    rst = 0;
    acc_m = 0;
  endtask

  // Full accumulator readback using MACW 0*0 (low word) and RDHI (high word).
  task automatic peek(output logic [63:0] val);
    obs_t o;
    issue(2'b01, 32'd0, 32'd0, 5'd1, 0, o);
    val[31:0] = o.res;
    issue(2'b10, 32'd0, 32'd0, 5'd1, 0, o);
    val[63:32] = o.res;
  endtask

  task automatic test_reset();
    rst = 0; in_valid_e = 0; flush_e = 0; op_e = 0; rs1_val_e = 0; rs2_val_e = 0; rd_e = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({result_valid_w, result_w, rd_w, busy_o} !== 39'd0) begin
      failures++; $display("FAIL reset_outputs got %h want 0", {result_valid_w, result_w, rd_w, busy_o});
    end
    checks++;
    if (in_ready_e !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", in_ready_e); end
    in_valid_e = 1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_idle_stall got %b want 0", stall_o); end
    in_valid_e = 0;
    @(negedge clk);
    rst = 0;
    acc_m = 0;
    #1;
    checks++;
    if (in_ready_e !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("FAIL release_ready got %b%b want 10", in_ready_e, busy_o);
    end
  endtask

  task automatic test_macw_basic();
    obs_t o; bit es; logic [31:0] er; int eb;
    model(2'b01, 32'd3, -32'sd4, 5'd5, es, er, eb);
    issue(2'b01, 32'd3, -32'sd4, 5'd5, 0, o);
    checks++;
    if (o.busy_cyc != 4 || o.stall_bad != 0) begin
      failures++; $display("FAIL macw_stall got busy=%0d bad=%0d want 4/0", o.busy_cyc, o.stall_bad);
    end
    checks++;
    if (o.strobes != 1 || o.strobe_at != 4) begin
      failures++; $display("FAIL macw_latency got n=%0d at=%0d want 1/4", o.strobes, o.strobe_at);
    end
    checks++;
    if (o.res !== 32'hFFFFFFF4 || o.rdw !== 5'd5) begin
      failures++; $display("FAIL macw_result got %h/%0d want fffffff4/5", o.res, o.rdw);
    end
  endtask

  task automatic test_rdhi_overflow();
    obs_t o; bit es; logic [31:0] er; int eb; logic [63:0] v;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      model(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd3, es, er, eb);
      issue(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd3, 0, o);
      checks++;
      if (o.strobes != 0 || o.busy_cyc != MC + 1 || o.leak != 0) begin
        failures++; $display("FAIL mac_silent got n=%0d busy=%0d leak=%0d want 0/%0d/0", o.strobes, o.busy_cyc, o.leak, MC + 1);
      end
    end
    issue(2'b10, 32'd0, 32'd0, 5'd7, 0, o);
    checks++;
    if (o.res !== 32'h7FFFFFFE || o.rdw !== 5'd7 || o.strobe_at != 1 || o.busy_cyc != 1) begin
      failures++; $display("FAIL rdhi got %h rd=%0d at=%0d busy=%0d want 7ffffffe/7/1/1", o.res, o.rdw, o.strobe_at, o.busy_cyc);
    end
    peek(v);
    checks++;
    if (v !== 64'h7FFFFFFE_00000002) begin failures++; $display("FAIL acc_overflow got %h want 7ffffffe00000002", v); end
  endtask

  task automatic test_flush();
    obs_t o; bit es; logic [31:0] er; int eb; logic [63:0] v; int seen;
    do_reset();
    model(2'b00, 32'h40000000, 32'h10, 5'd0, es, er, eb);
    issue(2'b00, 32'h40000000, 32'h10, 5'd0, 0, o);
    @(negedge clk);
    in_valid_e = 1; op_e = 2'b01; rs1_val_e = 123; rs2_val_e = 456; rd_e = 9;
    @(negedge clk);
    flush_e = 1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got %b want 0", stall_o); end
    @(negedge clk);
    flush_e = 0; in_valid_e = 0;
    #1;
    checks++;
    if (in_ready_e !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("FAIL flush_abort got ready=%b busy=%b want 1/0", in_ready_e, busy_o);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (result_valid_w) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_no_wb got %0d strobes want 0", seen); end
    peek(v);
    checks++;
    if (v !== acc_m) begin failures++; $display("FAIL flush_acc got %h want %h", v, acc_m); end
    @(negedge clk);
    in_valid_e = 1; op_e = 2'b11; flush_e = 1;
    @(negedge clk);
    in_valid_e = 0; flush_e = 0;
    peek(v);
    checks++;
    if (v !== acc_m) begin failures++; $display("FAIL idle_flush_accept got %h want %h", v, acc_m); end
  endtask

  task automatic test_rd_zero();
    obs_t o; bit es; logic [31:0] er; int eb; logic [63:0] v;
    model(2'b11, 0, 0, 0, es, er, eb);
    issue(2'b11, 32'd0, 32'd0, 5'd2, 0, o);
    checks++;
    if (o.busy_cyc != 0 || o.strobes != 0) begin
      failures++; $display("FAIL clr_idle got busy=%0d n=%0d want 0/0", o.busy_cyc, o.strobes);
    end
    model(2'b01, 32'd0, 32'd9, 5'd0, es, er, eb);
    issue(2'b01, 32'd0, 32'd9, 5'd0, 0, o);
    checks++;
    if (o.strobes != 0 || o.busy_cyc != MC + 1 || o.leak != 0) begin
      failures++; $display("FAIL rd0_suppress got n=%0d busy=%0d leak=%0d want 0/%0d/0", o.strobes, o.busy_cyc, o.leak, MC + 1);
    end
    peek(v);
    checks++;
    if (v !== 64'd0) begin failures++; $display("FAIL clr_acc got %h want 0", v); end
  endtask

  task automatic test_reset_mid();
    obs_t o; int seen;
    issue(2'b00, 32'd1000, 32'd1000, 5'd0, 0, o);
    @(negedge clk);
    in_valid_e = 1; op_e = 2'b01; rs1_val_e = 2; rs2_val_e = 2; rd_e = 4;
    @(negedge clk);
    in_valid_e = 0;
    @(posedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || in_ready_e !== 1'b1 || result_valid_w !== 1'b0) begin
      failures++; $display("FAIL async_reset got busy=%b ready=%b rv=%b want 0/1/0", busy_o, in_ready_e, result_valid_w);
    end
    @(negedge clk);
    rst = 0; acc_m = 0;
    #1;
    checks++;
    if (in_ready_e !== 1'b1) begin failures++; $display("FAIL post_reset_ready got %b want 1", in_ready_e); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (result_valid_w) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL reset_no_wb got %0d want 0", seen); end
    issue(2'b10, 32'd0, 32'd0, 5'd6, 0, o);
    checks++;
    if (o.res !== 32'd0 || o.strobes != 1) begin failures++; $display("FAIL reset_rdhi got %h n=%0d want 0/1", o.res, o.strobes); end
  endtask

  task automatic test_wrap();
    obs_t o; bit es; logic [31:0] er; int eb; logic [63:0] v;
    do_reset();
    model(2'b00, 32'hFFFFFFFF, 32'd1, 5'd0, es, er, eb);
    issue(2'b00, 32'hFFFFFFFF, 32'd1, 5'd0, 0, o);
    peek(v);
    checks++;
    if (v !== 64'hFFFFFFFF_FFFFFFFF) begin failures++; $display("FAIL wrap_setup got %h want all ones", v); end
    model(2'b01, 32'd1, 32'd1, 5'd3, es, er, eb);
    issue(2'b01, 32'd1, 32'd1, 5'd3, 0, o);
    checks++;
    if (o.res !== 32'd0 || o.strobes != 1 || o.rdw !== 5'd3) begin
      failures++; $display("FAIL wrap_result got %h n=%0d rd=%0d want 0/1/3", o.res, o.strobes, o.rdw);
    end
    peek(v);
    checks++;
    if (v !== 64'd0) begin failures++; $display("FAIL wrap_acc got %h want 0", v); end
  endtask

  task automatic test_back_to_back();
    bit es; logic [31:0] er; int eb; int waited; int seen; logic [31:0] got;
    model(2'b00, 32'd11, 32'd13, 5'd0, es, er, eb);
    @(negedge clk);
    in_valid_e = 1; op_e = 2'b00; rs1_val_e = 11; rs2_val_e = 13; rd_e = 0;
    waited = 0;
    @(negedge clk);
    while (!in_ready_e && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    checks++;
    if (waited != MC + 1) begin failures++; $display("FAIL b2b_hold got %0d busy cycles want %0d", waited, MC + 1); end
    model(2'b01, 32'd0, 32'd0, 5'd2, es, er, eb);
    op_e = 2'b01; rs1_val_e = 0; rs2_val_e = 0; rd_e = 2;
    @(negedge clk);
    in_valid_e = 0;
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b want 1", busy_o); end
    seen = 0; got = 0;
    for (int k = 0; k < MC + 3; k++) begin
      if (result_valid_w) begin seen++; got = result_w; end
      @(negedge clk);
    end
    checks++;
    if (seen != 1 || got !== er) begin failures++; $display("FAIL b2b_result got %h n=%0d want %h/1", got, seen, er); end
  endtask

  task automatic test_random();
    obs_t o; bit es; logic [31:0] er; int eb;
    logic [1:0] op; logic [31:0] a, b; logic [4:0] rd; bit fd;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b11 && $urandom_range(0, 2) != 0) op = 2'b01;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($signed(-$urandom_range(1, 5)));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      fd = 1'($urandom_range(0, 1));
      model(op, a, b, rd, es, er, eb);
      issue(op, a, b, rd, fd, o);
      checks++;
      if (o.busy_cyc != eb || o.stall_bad != 0 || o.timeout) begin
        failures++; $display("FAIL rand%0d_timing op=%0d got busy=%0d bad=%0d to=%0d want %0d/0/0", i, op, o.busy_cyc, o.stall_bad, o.timeout, eb);
      end
      checks++;
      if (o.strobes != int'(es) || o.leak != 0) begin
        failures++; $display("FAIL rand%0d_strobe op=%0d got n=%0d leak=%0d want %0d/0", i, op, o.strobes, o.leak, es);
      end
      if (es) begin
        checks++;
        if (o.res !== er || o.rdw !== rd || o.strobe_at != eb) begin
          failures++; $display("FAIL rand%0d_data op=%0d got %h rd=%0d at=%0d want %h/%0d/%0d", i, op, o.res, o.rdw, o.strobe_at, er, rd, eb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_macw_basic();
    test_rdhi_overflow();
    test_flush();
    test_rd_zero();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/mac_coprocessor.md
MAC_COPROCESSOR -- requirements
Module: mac_coprocessor

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3, meaning multiply cycles per MAC op; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid_e  input  1  execute stage presents a MAC-class instruction.
REQ-005 SHALL have port op_e  input  2  operation: 00 MAC, 01 MACW, 10 RDHI, 11 CLR.
REQ-006 SHALL have port rs1_val_e  input  32  forwarded operand A, two's complement.
REQ-007 SHALL have port rs2_val_e  input  32  forwarded operand B, two's complement.
REQ-008 SHALL have port rd_e  input  5  destination register.
REQ-009 SHALL have port flush_e  input  1  execute-stage flush from branch resolution.
REQ-010 SHALL have port in_ready_e  output  1  unit can accept an op this cycle.
REQ-011 SHALL have port stall_o  output  1  freeze fetch, decode and execute stages.
REQ-012 SHALL have port busy_o  output  1  unit is not IDLE.
REQ-013 SHALL have port result_valid_w  output  1  one-cycle writeback strobe.
REQ-014 SHALL have port result_w  output  32  writeback data.
REQ-015 SHALL have port rd_w  output  5  writeback destination.

Function
REQ-016 SHALL hold a 64-bit signed accumulator acc; all additions wrap modulo 2^64.
REQ-017 SHALL implement states IDLE, COMPUTE and DONE.
REQ-018 SHALL drive in_ready_e = 1 only in IDLE.
REQ-019 SHALL drive stall_o = in_valid_e & ~in_ready_e & ~flush_e, combinationally.
REQ-020 SHALL accept an op when in_valid_e & in_ready_e & ~flush_e; it SHALL capture operands, op and rd in that cycle.
REQ-021 SHALL perform MAC and MACW as acc <= acc + sext64(A) * sext64(B).
- On accept, go IDLE -> COMPUTE with a cycle counter set to 0.
- Stay in COMPUTE for MUL_CYCLES cycles.
- On the last COMPUTE cycle's edge, update acc and go to DONE.
- DONE lasts exactly 1 cycle, then returns to IDLE.
REQ-022 SHALL, for MACW only, assert result_valid_w in DONE with result_w = new acc[31:0] and rd_w = captured rd.
REQ-023 SHALL perform RDHI as: accept at T -> DONE at T+1, with result_w = acc[63:32] and acc unchanged.
REQ-024 SHALL perform CLR as: acc <= 0 on the accept edge, remain in IDLE, no writeback.
REQ-025 SHALL, for MAC, pass through DONE with result_valid_w = 0.
REQ-026 SHALL suppress result_valid_w when the captured rd = 0; the state sequence is unchanged.
REQ-027 SHALL hold result_w and rd_w at 0 whenever result_valid_w = 0.
REQ-028 SHALL, on flush_e while in COMPUTE, abort to IDLE on the next edge: acc unchanged, no DONE, no writeback.
REQ-029 SHALL ignore flush_e while in DONE; the writeback completes.
REQ-030 SHALL accept nothing when flush_e and in_valid_e are asserted in the same IDLE cycle.
REQ-031 SHALL have MAC/MACW latency from accept to writeback strobe = MUL_CYCLES + 1 cycles.
REQ-032 SHALL accept back-to-back ops no sooner than the cycle after DONE.

Reset
REQ-033 SHALL, on rst high and regardless of clk, force IDLE, acc = 0, counter = 0, result_valid_w = 0, result_w = 0 and rd_w = 0.
REQ-034 SHALL, on reset asserted mid-COMPUTE or in DONE, discard the op with no writeback after release.
REQ-035 SHALL, after rst deasserts, drive in_ready_e = 1 and busy_o = 0, with the first accept possible on the first clk edge.

Verification
REQ-036 SHALL pass: MACW A=3, B=-4, rd=5, from reset -> stall_o high for 4 cycles; result_valid_w at T+4 with result_w 0xFFFFFFF4 and rd_w 5.
REQ-037 SHALL pass: MAC 0x7FFFFFFF x 0x7FFFFFFF twice, then RDHI rd=7 -> result_w 0x7FFFFFFE, i.e. acc = 0x7FFFFFFE_00000002.
REQ-038 SHALL pass: MACW issued with flush_e high on the cycle after accept -> return to IDLE, no result_valid_w, RDHI returns the prior value.
REQ-039 SHALL pass: CLR then MACW A=0, B=9, rd=0 -> no result_valid_w, acc = 0.
REQ-040 SHALL pass: rst pulsed during COMPUTE of MACW A=2, B=2 -> no writeback, RDHI = 0, in_ready_e = 1 immediately after release.
REQ-041 SHALL pass: acc = 0xFFFFFFFF_FFFFFFFF, then MACW A=1, B=1 -> acc wraps to 0, result_w = 0.
